// File: rtl/dsi_frame_buf.sv
// dsi_frame_buf: frame-buffered, lane-parallel byte store between the SLIP
// decoder and the DSI transmitter. Bytes are held until their frame closes.
// Only committed frames are replayed, LANES bytes per word, under req/ack.
module dsi_frame_buf #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned FRM_W  = 2,
  parameter logic [7:0]  PAD    = 8'h00
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [7:0]           din,
  input  logic                 din_rdy,
  input  logic                 frame,
  output logic [8*LANES-1:0]   dout,
  output logic [LANES-1:0]     dout_keep,
  output logic                 dout_req,
  input  logic                 dout_ack,
  output logic                 dout_last,
  output logic                 b_req,
  output logic [FRM_W:0]       frames,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned QD    = 1 << FRM_W;

  localparam logic [PW-1:0]  BUF_FULL = PW'(DEPTH);
  localparam logic [FRM_W:0] Q_FULL   = (FRM_W + 1)'(QD);
  localparam logic [PW-1:0]  LANES_P  = PW'(LANES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [7:0]       r_mem  [DEPTH];
  logic [PW-1:0]    r_lenq [QD];

  logic             r_frame_q;
  logic             r_open;
  logic             r_drop;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_wr_start;
  logic [PW-1:0]    r_len;
  logic [FRM_W-1:0] r_q_wr;
  logic [FRM_W-1:0] r_q_rd;

  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_rd_cur;
  logic [PW-1:0]    r_rem;
  logic [PW-1:0]    r_cnt;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [8*LANES-1:0] r_dout;
  logic [LANES-1:0]   r_keep;
  logic               r_req;
  logic               r_last;
  logic               r_breq;
  logic [FRM_W:0]     r_frames;
  logic               r_ovf;

  logic               w_rise;
  logic               w_fall;
  logic               w_open;
  logic               w_drop;
  logic               w_full;
  logic               w_take;
  logic               w_wr_en;
  logic               w_set_drop;
  logic [PW-1:0]      w_len;
  logic               w_reject;
  logic               w_push;
  logic               w_pop;
  logic               w_done;
  logic [8*LANES-1:0] w_word;
  logic [LANES-1:0]   w_keep;
  logic [PW-1:0]      w_cnt;

  // Write-side frame tracking: a byte in the rising-edge cycle already belongs to the new frame
  assign w_rise     = frame & ~r_frame_q;
  assign w_fall     = ~frame & r_frame_q & r_open;
  assign w_open     = r_open | w_rise;
  assign w_drop     = r_drop & ~w_rise;
  assign w_len      = w_rise ? '0 : r_len;
  assign w_full     = (r_wr_ptr - r_rd_ptr) == BUF_FULL;
  assign w_take     = din_rdy & frame & w_open & ~w_drop;
  assign w_wr_en    = w_take & ~w_full;
  assign w_set_drop = w_take & w_full;
  assign w_reject   = w_fall & (r_drop | (r_frames == Q_FULL));
  assign w_push     = w_fall & ~w_reject & (r_len != '0);
  assign w_pop      = (r_state == S_IDLE) & (r_frames != '0);
  assign w_done     = (r_state == S_SEND) & r_req & dout_ack & r_last;

  // Byte store and committed-length queue (no reset: contents are qualified by pointers)
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[ADDR_W'(r_wr_ptr)] <= din;
    if (w_push)  r_lenq[r_q_wr] <= r_len;
  end

  // Write pointer, open-frame state, drop flag and commit/rollback
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_frame_q  <= 1'b1;
      r_open     <= 1'b0;
      r_drop     <= 1'b0;
      r_wr_ptr   <= '0;
      r_wr_start <= '0;
      r_len      <= '0;
      r_q_wr     <= '0;
    end else begin
      r_frame_q <= frame;
      r_drop    <= w_drop | w_set_drop;
      r_len     <= w_len + PW'(w_wr_en);
      if (w_rise) begin
        r_open     <= 1'b1;
        r_wr_start <= r_wr_ptr;
      end
      if (w_fall)   r_open   <= 1'b0;
      if (w_wr_en)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_reject) r_wr_ptr <= r_wr_start;
      if (w_push)   r_q_wr   <= r_q_wr + FRM_W'(1);
    end
  end

  // Committed-frame count and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_frames <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case ({w_push, w_done})
        2'b10:   r_frames <= r_frames + (FRM_W + 1)'(1);
        2'b01:   r_frames <= r_frames - (FRM_W + 1)'(1);
        default: r_frames <= r_frames;
      endcase
      if (w_reject)     r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Assemble the next output word from consecutive addresses, lane 0 lowest
  always_comb begin
    w_word = '0;
    w_keep = '0;
    w_cnt  = (r_rem < LANES_P) ? r_rem : LANES_P;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (PW'(i) < r_rem) begin
        w_word[8*i +: 8] = r_mem[ADDR_W'(r_rd_cur + PW'(i))];
        w_keep[i]        = 1'b1;
      end else begin
        w_word[8*i +: 8] = PAD;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Read FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SEND;
      S_SEND:  if (dout_ack) w_state_nxt = r_last ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read datapath: pop a frame length, present words, retire bytes on ack
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rd_ptr <= '0;
      r_rd_cur <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_q_rd   <= '0;
      r_dout   <= '0;
      r_keep   <= '0;
      r_req    <= 1'b0;
      r_last   <= 1'b0;
      r_breq   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_rem  <= r_lenq[r_q_rd];
            r_q_rd <= r_q_rd + FRM_W'(1);
            r_breq <= 1'b1;
          end
        end
        S_LOAD: begin
          r_dout <= w_word;
          r_keep <= w_keep;
          r_last <= (r_rem <= LANES_P);
          r_cnt  <= w_cnt;
          r_req  <= 1'b1;
        end
        S_SEND: begin
          if (dout_ack) begin
            r_req    <= 1'b0;
            r_rem    <= r_rem - r_cnt;
            r_rd_cur <= r_rd_cur + r_cnt;
            if (r_last) begin
              r_breq   <= 1'b0;
              r_rd_ptr <= r_rd_cur + r_cnt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dout      = r_dout;
  assign dout_keep = r_keep;
  assign dout_req  = r_req;
  assign dout_last = r_last;
  assign b_req     = r_breq;
  assign frames    = r_frames;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_dsi_frame_buf.sv
// Bench for dsi_frame_buf: two instances (2 lanes / 512 B, 4 lanes / 16 B),
// one selected at a time, checked against a byte/length scoreboard.
module tb_dsi_frame_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       sel;
  logic [7:0] din;
  logic       din_rdy;
  logic       frame;
  logic       ack;
  logic       ovf_clr;

  logic [15:0] a_dout;
  logic [1:0]  a_keep;
  logic        a_req, a_last, a_breq, a_ovf;
  logic [2:0]  a_frames;
  logic [31:0] b_dout;
  logic [3:0]  b_keep;
  logic        b_reqo, b_last, b_breq, b_ovf;
  logic [2:0]  b_frames;

  logic [31:0] m_dout;
  logic [3:0]  m_keep;
  logic        m_req, m_last, m_breq, m_ovf;
  logic [2:0]  m_frames;

  int total = 0;
  int bad   = 0;
  logic [7:0] q_byte[$];
  int         q_len[$];

  dsi_frame_buf #(.LANES(2), .ADDR_W(9), .FRM_W(2), .PAD(8'h00)) u_a (
    .clk(clk), .nrst(nrst), .din(din), .din_rdy(din_rdy & ~sel), .frame(frame & ~sel),
    .dout(a_dout), .dout_keep(a_keep), .dout_req(a_req), .dout_ack(ack & ~sel),
    .dout_last(a_last), .b_req(a_breq), .frames(a_frames), .ovf(a_ovf), .ovf_clr(ovf_clr)
  );

  dsi_frame_buf #(.LANES(4), .ADDR_W(4), .FRM_W(2), .PAD(8'hA5)) u_b (
    .clk(clk), .nrst(nrst), .din(din), .din_rdy(din_rdy & sel), .frame(frame & sel),
    .dout(b_dout), .dout_keep(b_keep), .dout_req(b_reqo), .dout_ack(ack & sel),
    .dout_last(b_last), .b_req(b_breq), .frames(b_frames), .ovf(b_ovf), .ovf_clr(ovf_clr)
  );

  assign m_dout   = sel ? b_dout   : {16'h0000, a_dout};
  assign m_keep   = sel ? b_keep   : {2'b00, a_keep};
  assign m_req    = sel ? b_reqo   : a_req;
  assign m_last   = sel ? b_last   : a_last;
  assign m_breq   = sel ? b_breq   : a_breq;
  assign m_ovf    = sel ? b_ovf    : a_ovf;
  assign m_frames = sel ? b_frames : a_frames;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dout"},   m_dout, 32'h0);
    chk({tag, "_keep"},   32'(m_keep), 32'h0);
    chk({tag, "_req"},    32'(m_req), 32'h0);
    chk({tag, "_last"},   32'(m_last), 32'h0);
    chk({tag, "_b_req"},  32'(m_breq), 32'h0);
    chk({tag, "_frames"}, 32'(m_frames), 32'h0);
    chk({tag, "_ovf"},    32'(m_ovf), 32'h0);
  endtask

  // Drive one frame; bytes expected to survive go to the scoreboard as they are driven
  task automatic wr_frame(input int n, input logic [7:0] base, input int gap, input bit commit);
    frame = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'(int'(base) + i + 13 * (i >> 8));
      din     = b;
      din_rdy = 1'b1;
      if (commit) q_byte.push_back(b);
      tick();
      din_rdy = 1'b0;
      repeat (gap) tick();
    end
    frame = 1'b0;
    if (commit && n > 0) q_len.push_back(n);
    tick();
  endtask

  // Read one frame from the selected instance, checking each word against the scoreboard
  task automatic rd_frame(input int hold);
    int n, rem, lanes, budget, w;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    logic [7:0]  pad, b;
    lanes  = sel ? 4 : 2;
    pad    = sel ? 8'hA5 : 8'h00;
    budget = 0;
    while (q_len.size() == 0 && budget < 3000) begin
      tick();
      budget++;
    end
    chk("len_avail", 32'(q_len.size() != 0), 32'h1);
    if (q_len.size() == 0) return;
    n   = q_len.pop_front();
    rem = n;
    w   = 0;
    while (rem > 0) begin
      budget = 0;
      while (!m_req && budget < 3000) begin
        tick();
        budget++;
      end
      chk("req_wait", 32'(m_req), 32'h1);
      if (!m_req) return;
      exp_d = '0;
      exp_k = '0;
      for (int i = 0; i < lanes; i++) begin
        if (i < rem) begin
          b = (q_byte.size() != 0) ? q_byte.pop_front() : 8'hxx;
          exp_d[8*i +: 8] = b;
          exp_k[i]        = 1'b1;
        end else begin
          exp_d[8*i +: 8] = pad;
        end
      end
      chk("dout",  m_dout, exp_d);
      chk("keep",  32'(m_keep), 32'(exp_k));
      chk("last",  32'(m_last), 32'(rem <= lanes));
      chk("b_req", 32'(m_breq), 32'h1);
      if (w == 0 && hold > 0) begin
        repeat (hold) tick();
        chk("hold_dout", m_dout, exp_d);
        chk("hold_req",  32'(m_req), 32'h1);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("req_drop", 32'(m_req), 32'h0);
      rem -= (rem < lanes) ? rem : lanes;
      w++;
    end
    chk("b_req_end", 32'(m_breq), 32'h0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; sel = 1'b0; din = 8'h00; din_rdy = 1'b0;
    frame = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    chk_idle_outputs("rst_a");
    sel = 1'b1;
    #1;
    chk_idle_outputs("rst_b");
    sel = 1'b0;
    nrst = 1'b1;
    tick();

    // 5-byte frame on 2 lanes, first word held before ack
    wr_frame(5, 8'h01, 0, 1'b1);
    chk("t1_frames_1", 32'(m_frames), 32'h1);
    rd_frame(3);
    chk("t1_frames_0", 32'(m_frames), 32'h0);
    chk("t1_ovf", 32'(m_ovf), 32'h0);

    // Empty frame pulse commits nothing
    frame = 1'b1;
    tick();
    frame = 1'b0;
    repeat (3) tick();
    chk("t4_frames", 32'(m_frames), 32'h0);
    chk("t4_ovf",    32'(m_ovf), 32'h0);
    chk("t4_req",    32'(m_req), 32'h0);

    // Five frames without ack: fifth overflows the frame queue
    for (int k = 0; k < 5; k++) wr_frame(2, 8'(8'h10 + 16 * k), 0, k < 4);
    chk("t3_frames_4", 32'(m_frames), 32'h4);
    chk("t3_ovf",      32'(m_ovf), 32'h1);
    for (int k = 0; k < 4; k++) rd_frame(0);
    chk("t3_frames_0", 32'(m_frames), 32'h0);
    repeat (4) tick();
    chk("t3_no_extra", 32'(m_req), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(m_ovf), 32'h0);

    // 4 lanes, 16-byte buffer: 20-byte frame drops (set beats a concurrent clear)
    sel = 1'b1;
    tick();
    ovf_clr = 1'b1;
    wr_frame(20, 8'h40, 0, 1'b0);
    ovf_clr = 1'b0;
    chk("t2_ovf",    32'(m_ovf), 32'h1);
    chk("t2_frames", 32'(m_frames), 32'h0);
    wr_frame(3, 8'h01, 0, 1'b1);
    chk("t2_frames_1", 32'(m_frames), 32'h1);
    rd_frame(0);
    chk("t2_frames_0", 32'(m_frames), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(m_ovf), 32'h0);
    sel = 1'b0;
    tick();

    // Two 300-byte frames with concurrent read; the second wraps the buffer
    fork
      begin
        wr_frame(300, 8'h20, 2, 1'b1);
        wr_frame(300, 8'h77, 2, 1'b1);
      end
      begin
        rd_frame(0);
        rd_frame(0);
      end
    join
    chk("t6_ovf",    32'(m_ovf), 32'h0);
    chk("t6_frames", 32'(m_frames), 32'h0);

    // Reset mid-frame with a committed frame pending
    wr_frame(3, 8'h90, 0, 1'b1);
    repeat (3) tick();
    chk("t5_pre_req", 32'(m_req), 32'h1);
    frame = 1'b1;
    tick();
    din = 8'hE0; din_rdy = 1'b1;
    tick();
    din = 8'hE1;
    tick();
    nrst = 1'b0;
    tick();
    chk_idle_outputs("t5_rst");
    nrst = 1'b1;
    din = 8'hE2;
    tick();
    din = 8'hE3;
    tick();
    din_rdy = 1'b0;
    chk("t5_mid_frames", 32'(m_frames), 32'h0);
    frame = 1'b0;
    repeat (3) tick();
    chk("t5_frames", 32'(m_frames), 32'h0);
    chk("t5_ovf",    32'(m_ovf), 32'h0);
    chk("t5_req",    32'(m_req), 32'h0);
    q_byte.delete();
    q_len.delete();
    wr_frame(4, 8'hC0, 0, 1'b1);
    rd_frame(0);
    chk("t5_frames_0", 32'(m_frames), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
